// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, word type and mode encoding for the ALU arithmetic slice
package alu_pkg;
    localparam int CLA_W = 8;
    localparam int CLA_GRP = 4;
    typedef logic signed [CLA_W-1:0] alu_word_t;
    typedef enum logic {ALU_ADD = 1'b0, ALU_SUB = 1'b1} alu_mode_e;
endpackage

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit lookahead group producing internal carries, group generate/propagate and sum bits
module cla_4bit
    import alu_pkg::*;
(
    input  logic [CLA_GRP-1:0] p,
    input  logic [CLA_GRP-1:0] g,
    input  logic               cin,
    output logic [3:1]         c,
    output logic               gg,
    output logic               gp,
    output logic [CLA_GRP-1:0] s
);
    // every carry is a flat sum of products; no ripple between bits
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
    assign s = p ^ {c, cin};
endmodule

// File: rtl/cla_8bit.sv
// cla_8bit: registered 8-bit signed add/subtract on two 4-bit lookahead groups with carry and overflow flags
module cla_8bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             mode,
    output logic [CLA_W-1:0] sum,
    output logic             cout,
    output logic             ovfl
);
    alu_word_t        bx;
    logic [CLA_W-1:0] p, g, s;
    logic [3:1]       c_lo, c_hi;
    logic             c0, c4, c8, gg0, gp0, gg1, gp1;
    logic             unused_c;

    assign c0 = alu_mode_e'(mode) == ALU_SUB;
    assign bx = b ^ {CLA_W{c0}};
    assign p = a ^ bx;
    assign g = a & bx;

    cla_4bit u_lo (.p(p[3:0]), .g(g[3:0]), .cin(c0), .c(c_lo), .gg(gg0), .gp(gp0), .s(s[3:0]));
    cla_4bit u_hi (.p(p[7:4]), .g(g[7:4]), .cin(c4), .c(c_hi), .gg(gg1), .gp(gp1), .s(s[7:4]));

    assign c4 = gg0 | (gp0 & c0);
    assign c8 = gg1 | (gp1 & gg0) | (gp1 & gp0 & c0);
    // only the carry into bit 7 is needed beyond the group carries
    assign unused_c = ^{c_lo, c_hi[2:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovfl <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c8;
            ovfl <= c8 ^ c_hi[3];
        end
    end
endmodule

// File: tb/tb_cla_8bit.sv
// tb_cla_8bit: scoreboard bench for cla_8bit with directed vectors, async reset and a random sweep
module tb_cla_8bit;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        string      n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       mode = 1'b0;
    logic [7:0] sum;
    logic       cout, ovfl;
    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];

    cla_8bit dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode), .sum(sum), .cout(cout), .ovfl(ovfl));

    always #5 clk = ~clk;

    function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic m);
        exp_t       e;
        logic [8:0] t;
        int         sx, sy, r;
        t  = {1'b0, x} + {1'b0, m ? ~y : y} + {8'd0, m};
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = m ? sx - sy : sx + sy;
        e.s = t[7:0];
        e.c = t[8];
        e.o = (r > 127) || (r < -128);
        e.n = "rand";
        return e;
    endfunction

    task automatic check(string n, logic [7:0] es, logic ec, logic eo);
        checks++;
        if (sum !== es || cout !== ec || ovfl !== eo) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b ovfl=%b, want sum=%h cout=%b ovfl=%b",
                     n, sum, cout, ovfl, es, ec, eo);
        end
    endtask

    task automatic apply(string n, logic [7:0] x, logic [7:0] y, logic m,
                         logic [7:0] es, logic ec, logic eo);
        exp_t e;
        @(negedge clk);
        a = x;
        b = y;
        mode = m;
        e.s = es;
        e.c = ec;
        e.o = eo;
        e.n = n;
        q.push_back(e);
    endtask

    // monitor: one result appears per rising edge, one cycle after its inputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.n, e.s, e.c, e.o);
            end
        end
    end

    initial begin
        exp_t e;
        logic [7:0] x, y;
        logic       m;
        #1;
        check("reset_init", 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply("add_5_3",      8'd5,   8'd3,   1'b0, 8'h08, 1'b0, 1'b0);
        apply("add_127_1",    8'd127, 8'd1,   1'b0, 8'h80, 1'b0, 1'b1);
        apply("add_m1_1",     8'hFF,  8'd1,   1'b0, 8'h00, 1'b1, 1'b0);
        apply("sub_3_5",      8'd3,   8'd5,   1'b1, 8'hFE, 1'b0, 1'b0);
        apply("sub_m128_1",   8'h80,  8'd1,   1'b1, 8'h7F, 1'b1, 1'b1);
        apply("sub_0_m128",   8'h00,  8'h80,  1'b1, 8'h80, 1'b0, 1'b1);
        apply("sub_x_x",      8'h5A,  8'h5A,  1'b1, 8'h00, 1'b1, 1'b0);
        apply("b2b_10_20",    8'd10,  8'd20,  1'b0, 8'h1E, 1'b0, 1'b0);
        apply("b2b_100_50",   8'd100, 8'd50,  1'b1, 8'h32, 1'b1, 1'b0);
        apply("b2b_m50_m100", 8'hCE,  8'h9C,  1'b0, 8'h6A, 1'b1, 1'b1);
        apply("b2b_0_0",      8'h00,  8'h00,  1'b0, 8'h00, 1'b0, 1'b0);
        apply("b2b_m1_m1",    8'hFF,  8'hFF,  1'b1, 8'h00, 1'b1, 1'b0);
        apply("b2b_m128x2",   8'h80,  8'h80,  1'b0, 8'h00, 1'b1, 1'b1);
        apply("pre_rst",      8'd7,   8'd8,   1'b0, 8'h0F, 1'b0, 1'b0);

        // reset lands between edges while an operation is in flight
        @(negedge clk);
        a = 8'd100;
        b = 8'd27;
        mode = 1'b0;
        e.s = 8'h00; e.c = 1'b0; e.o = 1'b0; e.n = "rst_inflight";
        q.push_back(e);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h7F;
        b = 8'h7F;
        e.n = "rst_hold";
        q.push_back(e);
        @(negedge clk);
        a = 8'd20;
        b = 8'd22;
        #2 rst_n = 1'b1;
        e.s = 8'h2A; e.c = 1'b0; e.o = 1'b0; e.n = "rst_first";
        q.push_back(e);

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            m = 1'($urandom);
            e = model(x, y, m);
            apply("rand", x, y, m, e.s, e.c, e.o);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
